// File: rtl/alu64_issue_arbiter.sv
// Round-robin issue arbiter sharing one ALU64 among NREQ requesters. In-flight ops ride a
// {valid,ID,DST} shadow pipe matching the ALU latency and block same-ID/same-DST reissue.
module alu64_issue_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned ALU_LAT = 2
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [NREQ-1:0]      REQ,
   input  logic [3*NREQ-1:0]    REQ_OP,
   input  logic [4*NREQ-1:0]    REQ_DST,
   input  logic [8*NREQ-1:0]    REQ_SIZE,
   input  logic [NREQ-1:0]      REQ_CIN,
   input  logic [64*NREQ-1:0]   REQ_A,
   input  logic [64*NREQ-1:0]   REQ_B,
   input  logic [64*NREQ-1:0]   REQ_C,
   input  logic [64*NREQ-1:0]   REQ_D,
   input  logic                 HOLD,
   output logic [NREQ-1:0]      GNT,
   output logic                 ALU_ACT,
   output logic [2:0]           ALU_OP,
   output logic [3:0]           ALU_DST,
   output logic [1:0]           ALU_SA,
   output logic [1:0]           ALU_SB,
   output logic [1:0]           ALU_SC,
   output logic [1:0]           ALU_SD,
   output logic                 ALU_CIN,
   output logic [63:0]          ALU_A,
   output logic [63:0]          ALU_B,
   output logic [63:0]          ALU_C,
   output logic [63:0]          ALU_D,
   input  logic [63:0]          ALU_R,
   input  logic [1:0]           ALU_SR,
   input  logic [2:0]           ALU_FLAGS,
   output logic                 RSP_VALID,
   output logic [IDW-1:0]       RSP_ID,
   output logic [3:0]           RSP_DST,
   output logic [63:0]          RSP_R,
   output logic [1:0]           RSP_SR,
   output logic [2:0]           RSP_FLAGS,
   output logic                 BUSY
);

   logic [IDW-1:0]              rr_q, rr_d;
   logic                        act_q;
   logic [IDW-1:0]              id_q;
   logic [2:0]                  op_q;
   logic [3:0]                  dst_q;
   logic [7:0]                  size_q;
   logic                        cin_q;
   logic [63:0]                 a_q, b_q, c_q, d_q;
   logic [ALU_LAT-1:0]          sh_v_q;
   logic [ALU_LAT-1:0][IDW-1:0] sh_id_q;
   logic [ALU_LAT-1:0][3:0]     sh_dst_q;

   logic [NREQ-1:0]             blocked, elig, gnt;
   logic                        gnt_vld;
   logic [IDW-1:0]              gidx;
   logic [2:0]                  sel_op;
   logic [3:0]                  sel_dst;
   logic [7:0]                  sel_size;
   logic                        sel_cin;
   logic [63:0]                 sel_a, sel_b, sel_c, sel_d;

   always_comb begin
      blocked = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (act_q && id_q == IDW'(i) && dst_q == REQ_DST[4*i +: 4])
            blocked[i] = 1'b1;
         for (int unsigned s = 0; s < ALU_LAT; s++) begin
            if (sh_v_q[s] && sh_id_q[s] == IDW'(i) && sh_dst_q[s] == REQ_DST[4*i +: 4])
               blocked[i] = 1'b1;
         end
      end
   end

   assign elig = REQ & ~blocked & {NREQ{~HOLD}};

   // First pass searches rr_q..NREQ-1, second pass wraps around to 0..rr_q-1.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      gidx    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!gnt_vld && elig[i] && i >= 32'(rr_q)) begin
            gnt_vld = 1'b1;
            gnt[i]  = 1'b1;
            gidx    = IDW'(i);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!gnt_vld && elig[i]) begin
            gnt_vld = 1'b1;
            gnt[i]  = 1'b1;
            gidx    = IDW'(i);
         end
      end
   end

   always_comb begin
      sel_op   = '0;
      sel_dst  = '0;
      sel_size = '0;
      sel_cin  = 1'b0;
      sel_a    = '0;
      sel_b    = '0;
      sel_c    = '0;
      sel_d    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_op   = REQ_OP[3*i +: 3];
            sel_dst  = REQ_DST[4*i +: 4];
            sel_size = REQ_SIZE[8*i +: 8];
            sel_cin  = REQ_CIN[i];
            sel_a    = REQ_A[64*i +: 64];
            sel_b    = REQ_B[64*i +: 64];
            sel_c    = REQ_C[64*i +: 64];
            sel_d    = REQ_D[64*i +: 64];
         end
      end
   end

   assign rr_d = (32'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rr_q     <= '0;
         act_q    <= 1'b0;
         id_q     <= '0;
         op_q     <= '0;
         dst_q    <= '0;
         size_q   <= '0;
         cin_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         d_q      <= '0;
         sh_v_q   <= '0;
         sh_id_q  <= '0;
         sh_dst_q <= '0;
      end else begin
         act_q <= gnt_vld;
         if (gnt_vld) begin
            rr_q   <= rr_d;
            id_q   <= gidx;
            op_q   <= sel_op;
            dst_q  <= sel_dst;
            size_q <= sel_size;
            cin_q  <= sel_cin;
            a_q    <= sel_a;
            b_q    <= sel_b;
            c_q    <= sel_c;
            d_q    <= sel_d;
         end
         sh_v_q[0]   <= act_q;
         sh_id_q[0]  <= id_q;
         sh_dst_q[0] <= dst_q;
         for (int unsigned s = 1; s < ALU_LAT; s++) begin
            sh_v_q[s]   <= sh_v_q[s-1];
            sh_id_q[s]  <= sh_id_q[s-1];
            sh_dst_q[s] <= sh_dst_q[s-1];
         end
      end
   end

   assign GNT       = gnt;
   assign ALU_ACT   = act_q;
   assign ALU_OP    = op_q;
   assign ALU_DST   = dst_q;
   assign ALU_SA    = size_q[1:0];
   assign ALU_SB    = size_q[3:2];
   assign ALU_SC    = size_q[5:4];
   assign ALU_SD    = size_q[7:6];
   assign ALU_CIN   = cin_q;
   assign ALU_A     = a_q;
   assign ALU_B     = b_q;
   assign ALU_C     = c_q;
   assign ALU_D     = d_q;
   assign RSP_VALID = sh_v_q[ALU_LAT-1];
   assign RSP_ID    = sh_id_q[ALU_LAT-1];
   assign RSP_DST   = sh_dst_q[ALU_LAT-1];
   assign RSP_R     = ALU_R;
   assign RSP_SR    = ALU_SR;
   assign RSP_FLAGS = ALU_FLAGS;
   assign BUSY      = act_q | (|sh_v_q);

endmodule

// File: tb/tb_alu64_issue_arbiter.sv
// Bench for alu64_issue_arbiter: a two-stage ALU64 stand-in, directed scenarios and a
// randomized run against an in-flight-list reference model.
module tb_alu64_issue_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;
   localparam int unsigned LAT  = 2;

   logic                CLK = 1'b0;
   logic                RESET = 1'b1;
   logic [NREQ-1:0]     req = '0, req_cin = '0;
   logic [3*NREQ-1:0]   req_op = '0;
   logic [4*NREQ-1:0]   req_dst = '0;
   logic [8*NREQ-1:0]   req_size = '0;
   logic [64*NREQ-1:0]  req_a = '0, req_b = '0, req_c = '0, req_d = '0;
   logic                hold = 1'b0;
   logic [NREQ-1:0]     GNT;
   logic                ALU_ACT, ALU_CIN, RSP_VALID, BUSY;
   logic [2:0]          ALU_OP, RSP_FLAGS;
   logic [3:0]          ALU_DST, RSP_DST;
   logic [1:0]          ALU_SA, ALU_SB, ALU_SC, ALU_SD, RSP_SR;
   logic [63:0]         ALU_A, ALU_B, ALU_C, ALU_D, RSP_R;
   logic [IDW-1:0]      RSP_ID;
   logic [63:0]         p1_r = '0, p2_r = '0;
   logic [1:0]          p1_sr = '0, p2_sr = '0;
   int                  vec = 0, err = 0;

   typedef struct { int id; int dst; int t; logic [63:0] r; logic [1:0] sr; } op_t;

   function automatic logic [63:0] alu_fn(input logic [2:0] op, input logic [63:0] a, b, c, d,
                                          input logic cin);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return a + b + {63'd0, cin};
         3'd4: return a - b;
         3'd5: return (a & b) | (c & ~b);
         3'd6: return a + c;
         default: return d;
      endcase
   endfunction

   always #5 CLK = ~CLK;

   // ALU64 stand-in: result appears two cycles after the input registers.
   always @(posedge CLK) begin
      p1_r  <= alu_fn(ALU_OP, ALU_A, ALU_B, ALU_C, ALU_D, ALU_CIN);
      p1_sr <= ALU_SA;
      p2_r  <= p1_r;
      p2_sr <= p1_sr;
   end

   alu64_issue_arbiter #(.NREQ(NREQ), .IDW(IDW), .ALU_LAT(LAT)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(req), .REQ_OP(req_op), .REQ_DST(req_dst),
      .REQ_SIZE(req_size), .REQ_CIN(req_cin), .REQ_A(req_a), .REQ_B(req_b), .REQ_C(req_c),
      .REQ_D(req_d), .HOLD(hold), .GNT(GNT), .ALU_ACT(ALU_ACT), .ALU_OP(ALU_OP),
      .ALU_DST(ALU_DST), .ALU_SA(ALU_SA), .ALU_SB(ALU_SB), .ALU_SC(ALU_SC), .ALU_SD(ALU_SD),
      .ALU_CIN(ALU_CIN), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_C(ALU_C), .ALU_D(ALU_D),
      .ALU_R(p2_r), .ALU_SR(p2_sr), .ALU_FLAGS({1'b0, p2_r == 64'd0, p2_r[63]}),
      .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DST(RSP_DST), .RSP_R(RSP_R),
      .RSP_SR(RSP_SR), .RSP_FLAGS(RSP_FLAGS), .BUSY(BUSY)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_reqs();
      req = '0;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] dst,
                          input logic [7:0] size, input logic cin,
                          input logic [63:0] a, b, c, d);
      req[i]            = 1'b1;
      req_op[3*i +: 3]  = op;
      req_dst[4*i +: 4] = dst;
      req_size[8*i +: 8] = size;
      req_cin[i]        = cin;
      req_a[64*i +: 64] = a;
      req_b[64*i +: 64] = b;
      req_c[64*i +: 64] = c;
      req_d[64*i +: 64] = d;
   endtask

   task automatic do_reset();
      clear_reqs();
      hold  = 1'b0;
      RESET = 1'b1;
      step();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      clear_reqs();
      RESET = 1'b1;
      #1;
      vec++; if (ALU_ACT !== 1'b0) begin err++; $display("FAIL reset_act got=%b exp=0", ALU_ACT); end
      vec++; if (BUSY !== 1'b0) begin err++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      vec++; if (ALU_A !== 64'd0) begin err++; $display("FAIL reset_alu_a got=%h exp=0", ALU_A); end
      step();
      RESET = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) set_req(i, 3'd3, 4'(i + 1), 8'd0, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0);
      for (int c = 0; c < 3; c++) begin
         #1;
         vec++; if (GNT !== 4'(1 << c)) begin err++; $display("FAIL reset_pre_gnt c=%0d got=%b exp=%b", c, GNT, 4'(1 << c)); end
         step();
      end
      clear_reqs();
      RESET = 1'b1;
      #1;
      vec++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin err++; $display("FAIL reset_mid got valid=%b busy=%b exp=0/0", RSP_VALID, BUSY); end
      step();
      RESET = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         vec++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin err++; $display("FAIL reset_drop c=%0d got valid=%b busy=%b exp=0/0", c, RSP_VALID, BUSY); end
      end
      for (int i = 0; i < int'(NREQ); i++) set_req(i, 3'd3, 4'(i + 1), 8'd0, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0);
      #1;
      vec++; if (GNT !== 4'b0001) begin err++; $display("FAIL reset_rr got=%b exp=0001", GNT); end
      clear_reqs();
   endtask

   task automatic test_single();
      do_reset();
      set_req(2, 3'b011, 4'd9, 8'd0, 1'b1, 64'd5, 64'd7, 64'd0, 64'd0);
      #1;
      vec++; if (GNT !== 4'b0100) begin err++; $display("FAIL single_gnt got=%b exp=0100", GNT); end
      step();
      clear_reqs();
      #1;
      vec++; if (ALU_ACT !== 1'b1 || ALU_OP !== 3'b011 || ALU_A !== 64'd5 || ALU_B !== 64'd7 || ALU_CIN !== 1'b1)
         begin err++; $display("FAIL single_issue got act=%b op=%b a=%0d b=%0d cin=%b exp 1/011/5/7/1", ALU_ACT, ALU_OP, ALU_A, ALU_B, ALU_CIN); end
      step();
      vec++; if (RSP_VALID !== 1'b0 || ALU_ACT !== 1'b0) begin err++; $display("FAIL single_t2 got valid=%b act=%b exp=0/0", RSP_VALID, ALU_ACT); end
      step();
      vec++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'd2 || RSP_DST !== 4'd9 || RSP_R !== 64'd13)
         begin err++; $display("FAIL single_rsp got v=%b id=%0d dst=%0d r=%0d exp 1/2/9/13", RSP_VALID, RSP_ID, RSP_DST, RSP_R); end
      step();
      vec++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin err++; $display("FAIL single_done got valid=%b busy=%b exp=0/0", RSP_VALID, BUSY); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (c < 5) begin
            for (int i = 0; i < int'(NREQ); i++) set_req(i, 3'd3, 4'(i + 4), 8'd0, 1'b0, 64'(i + 1), 64'd10, 64'd0, 64'd0);
         end else clear_reqs();
         #1;
         if (c < 5) begin
            vec++; if (GNT !== 4'(1 << (c % 4))) begin err++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, GNT, 4'(1 << (c % 4))); end
         end
         if (c >= 3) begin
            vec++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'((c - 3) % 4) || RSP_R !== 64'((c - 3) % 4 + 11))
               begin err++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d r=%0d exp 1/%0d/%0d", c, RSP_VALID, RSP_ID, RSP_R, (c - 3) % 4, (c - 3) % 4 + 11); end
         end
         step();
      end
   endtask

   task automatic test_scoreboard();
      logic [3:0] exp;
      do_reset();
      set_req(1, 3'd0, 4'd5, 8'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) set_req(0, 3'd0, 4'd5, 8'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
         if (c == 2) req[0] = 1'b0;
         exp = (c == 0 || c == 4) ? 4'b0010 : (c == 1) ? 4'b0001 : 4'b0000;
         #1;
         vec++; if (GNT !== exp) begin err++; $display("FAIL sb_same_dst c=%0d got=%b exp=%b", c, GNT, exp); end
         step();
      end
      do_reset();
      set_req(1, 3'd0, 4'd5, 8'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
      step();
      set_req(1, 3'd0, 4'd6, 8'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
      #1;
      vec++; if (GNT !== 4'b0010) begin err++; $display("FAIL sb_new_dst got=%b exp=0010", GNT); end
      step();
      clear_reqs();
   endtask

   task automatic test_hold();
      do_reset();
      set_req(0, 3'd3, 4'd1, 8'd0, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0);
      set_req(1, 3'd3, 4'd2, 8'd0, 1'b0, 64'd3, 64'd4, 64'd0, 64'd0);
      #1;
      vec++; if (GNT !== 4'b0001) begin err++; $display("FAIL hold_pre0 got=%b exp=0001", GNT); end
      step();
      #1;
      vec++; if (GNT !== 4'b0010) begin err++; $display("FAIL hold_pre1 got=%b exp=0010", GNT); end
      step();
      hold = 1'b1;
      for (int c = 2; c < 6; c++) begin
         #1;
         vec++; if (GNT !== 4'b0000) begin err++; $display("FAIL hold_gnt c=%0d got=%b exp=0000", c, GNT); end
         vec++; if (RSP_VALID !== (c == 3 || c == 4)) begin err++; $display("FAIL hold_rsp c=%0d got=%b exp=%b", c, RSP_VALID, (c == 3 || c == 4)); end
         if (c == 3 || c == 4) begin
            vec++; if (RSP_ID !== 2'(c - 3) || RSP_R !== 64'(4 * (c - 3) + 3))
               begin err++; $display("FAIL hold_rsp_data c=%0d got id=%0d r=%0d exp %0d/%0d", c, RSP_ID, RSP_R, c - 3, 4 * (c - 3) + 3); end
         end
         step();
      end
      hold = 1'b0;
      #1;
      vec++; if (GNT !== 4'b0001) begin err++; $display("FAIL hold_resume0 got=%b exp=0001", GNT); end
      step();
      #1;
      vec++; if (GNT !== 4'b0010) begin err++; $display("FAIL hold_resume1 got=%b exp=0010", GNT); end
      step();
      clear_reqs();
   endtask

   task automatic test_bitcopy();
      do_reset();
      set_req(3, 3'b101, 4'd2, 8'd0, 1'b0, 64'hFF, 64'h0F, 64'd0, 64'd0);
      #1;
      vec++; if (GNT !== 4'b1000) begin err++; $display("FAIL bitcopy_gnt got=%b exp=1000", GNT); end
      step();
      clear_reqs();
      step();
      step();
      vec++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'd3 || RSP_R !== 64'h0F)
         begin err++; $display("FAIL bitcopy_rsp got v=%b id=%0d r=%h exp 1/3/0f", RSP_VALID, RSP_ID, RSP_R); end
   endtask

   task automatic test_random();
      op_t        fl[$];
      op_t        e;
      int         rr = 0;
      int         g;
      bit         busy_e;
      logic [3:0] exp_gnt;
      do_reset();
      for (int t = 0; t < 406; t++) begin
         hold = (t < 400) && ($urandom_range(0, 5) == 0);
         if (t < 400) begin
            for (int i = 0; i < int'(NREQ); i++)
               if (!req[i] && $urandom_range(0, 1) == 1)
                  set_req(i, 3'($urandom), 4'($urandom_range(0, 3)), 8'($urandom), 1'($urandom),
                          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
         end
         #1;
         g = -1;
         for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            bit blk;
            i = (rr + k) % int'(NREQ);
            blk = 1'b0;
            foreach (fl[j])
               if (fl[j].id == i && fl[j].dst == int'(req_dst[4*i +: 4]) && t > fl[j].t && t <= fl[j].t + 1 + int'(LAT))
                  blk = 1'b1;
            if (g < 0 && req[i] && !hold && !blk) g = i;
         end
         exp_gnt = '0;
         if (g >= 0) exp_gnt[g] = 1'b1;
         vec++; if (GNT !== exp_gnt) begin err++; $display("FAIL rand_gnt t=%0d got=%b exp=%b", t, GNT, exp_gnt); end
         busy_e = 1'b0;
         foreach (fl[j]) if (fl[j].t < t) busy_e = 1'b1;
         vec++; if (BUSY !== busy_e) begin err++; $display("FAIL rand_busy t=%0d got=%b exp=%b", t, BUSY, busy_e); end
         if (fl.size() > 0 && fl[0].t + 1 + int'(LAT) == t) begin
            e = fl.pop_front();
            vec++;
            if (RSP_VALID !== 1'b1 || int'(RSP_ID) != e.id || int'(RSP_DST) != e.dst || RSP_R !== e.r ||
                RSP_SR !== e.sr || RSP_FLAGS !== {1'b0, e.r == 64'd0, e.r[63]}) begin
               err++;
               $display("FAIL rand_rsp t=%0d got v=%b id=%0d dst=%0d r=%h sr=%0d fl=%b exp 1/%0d/%0d/%h/%0d",
                        t, RSP_VALID, RSP_ID, RSP_DST, RSP_R, RSP_SR, RSP_FLAGS, e.id, e.dst, e.r, e.sr);
            end
         end else begin
            vec++; if (RSP_VALID !== 1'b0) begin err++; $display("FAIL rand_idle t=%0d got=%b exp=0", t, RSP_VALID); end
         end
         if (g >= 0) begin
            e.id  = g;
            e.dst = int'(req_dst[4*g +: 4]);
            e.t   = t;
            e.r   = alu_fn(req_op[3*g +: 3], req_a[64*g +: 64], req_b[64*g +: 64],
                           req_c[64*g +: 64], req_d[64*g +: 64], req_cin[g]);
            e.sr  = req_size[8*g +: 2];
            fl.push_back(e);
            rr = (g + 1) % int'(NREQ);
         end
         step();
         if (g >= 0) req[g] = 1'b0;
      end
      clear_reqs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_scoreboard();
      test_hold();
      test_bitcopy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
